// File: rtl/m_mem_pkg.sv
// Shared codes and helpers for the M-stage data-memory controller.
// Holds ext/size op codes, FSM state encoding and byte-lane steering functions.
package m_mem_pkg;

  localparam logic [2:0] EXT_NONE   = 3'd0;
  localparam logic [2:0] EXT_U_BYTE = 3'd1;
  localparam logic [2:0] EXT_S_BYTE = 3'd2;
  localparam logic [2:0] EXT_U_HALF = 3'd3;
  localparam logic [2:0] EXT_S_HALF = 3'd4;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_HALF: misaligned = lo[0];
      SIZE_BYTE: misaligned = 1'b0;
      default:   misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_byteen(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_HALF: lane_byteen = lo[1] ? BE_HALF_HI : BE_HALF_LO;
      SIZE_BYTE: lane_byteen = BE_BYTE0 << lo;
      default:   lane_byteen = BE_WORD;
    endcase
  endfunction

  // Replicate the right-aligned store data into every lane it could occupy.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] w);
    case (size)
      SIZE_HALF: lane_wdata = {2{w[15:0]}};
      SIZE_BYTE: lane_wdata = {4{w[7:0]}};
      default:   lane_wdata = w;
    endcase
  endfunction

endpackage

// File: rtl/m_mem_ctrl_load_ext.sv
// Load lane select plus sign/zero extension of the returned memory word.
// Purely combinational.
module m_load_ext
  import m_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  ext,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (ext)
      EXT_U_BYTE: result = {24'b0, b};
      EXT_S_BYTE: result = {{24{b[7]}}, b};
      EXT_U_HALF: result = {16'b0, h};
      EXT_S_HALF: result = {{16{h[15]}}, h};
      default:    result = word;
    endcase
  end

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage load/store controller: req/ack memory port, pipeline stall, misalign and timeout detection.
// Memory-facing outputs are registered and hold the latched request for the whole ISSUE phase.
module m_mem_ctrl
  import m_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [2:0]  req_ext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state, state_nxt;
  logic [7:0]  cnt;
  logic [1:0]  lat_lane;
  logic [2:0]  lat_ext;
  logic [31:0] ext_dat;
  logic        mis, accept, timeout_hit;

  m_load_ext u_load_ext (
    .word   (mem_rdata),
    .lane   (lat_lane),
    .ext    (lat_ext),
    .result (ext_dat)
  );

  assign mis         = misaligned(req_size, req_addr[1:0]);
  assign timeout_hit = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    exc_adel  = 1'b0;
    exc_ades  = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (mis) begin
            exc_adel = !req_we;
            exc_ades = req_we;
          end else begin
            accept    = 1'b1;
            stall     = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        stall = 1'b1;
        if (mem_ack || timeout_hit) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      lat_lane    <= 2'd0;
      lat_ext     <= EXT_NONE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_byteen  <= 4'd0;
      mem_wdata   <= 32'd0;
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mem_req    <= 1'b1;
            mem_we     <= req_we;
            mem_addr   <= {req_addr[31:2], 2'b00};
            mem_byteen <= lane_byteen(req_size, req_addr[1:0]);
            mem_wdata  <= lane_wdata(req_size, req_wdata);
            lat_lane   <= req_addr[1:0];
            lat_ext    <= req_ext;
            cnt        <= 8'd0;
          end
        end
        ST_ISSUE: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            rdata       <= ext_dat;
            rdata_valid <= !mem_we;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            rdata   <= 32'd0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          rdata_valid <= 1'b0;
          bus_err     <= 1'b0;
          cnt         <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Directed bench for m_mem_ctrl with TIMEOUT=4; inputs driven #1 after posedge, outputs sampled on negedge.
module tb_m_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [1:0]  req_size;
  logic [2:0]  req_ext;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, exc_adel, exc_ades, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;

  int n_tests = 0;
  int n_fail  = 0;

  int          r_stall, r_req, r_done;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_be;
  logic        r_rv, r_err, r_we;

  always #5 clk = ~clk;

  m_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_ext    (req_ext),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .exc_adel   (exc_adel),
    .exc_ades   (exc_ades),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; ack_at is the cycle offset from acceptance (0 = never ack).
  task automatic run_op(input logic we, input logic [1:0] size, input logic [2:0] ext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mrd, input int ack_at);
    bit found = 0;
    r_stall = 0; r_req = 0; r_done = -1;
    r_rdata = '0; r_addr = '0; r_wdata = '0; r_be = '0; r_rv = 0; r_err = 0; r_we = 0;
    req_valid = 1; req_we = we; req_size = size; req_ext = ext;
    req_addr = addr; req_wdata = wdata; mem_rdata = mrd;
    for (int cyc = 0; cyc < 40 && !found; cyc++) begin
      mem_ack = (ack_at != 0) && (cyc == ack_at);
      @(negedge clk);
      if (cyc > 0 && !stall) begin
        found   = 1;
        r_done  = cyc;
        r_rdata = rdata;
        r_rv    = rdata_valid;
        r_err   = bus_err;
      end else begin
        if (stall) r_stall++;
        if (mem_req) begin
          r_req++;
          r_be = mem_byteen; r_addr = mem_addr; r_wdata = mem_wdata; r_we = mem_we;
        end
        @(posedge clk); #1;
      end
    end
    req_valid = 0;
    mem_ack   = 0;
    check("op_completes", 32'(found), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("pulse_ends", {30'd0, rdata_valid, bus_err}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit any_req;
    reset = 1; req_valid = 0; req_we = 0; req_size = 0; req_ext = 0;
    req_addr = 0; req_wdata = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mem_req",  32'(mem_req), 32'd0);
    check("rst_mem_we",   32'(mem_we), 32'd0);
    check("rst_byteen",   32'(mem_byteen), 32'd0);
    check("rst_addr",     mem_addr, 32'd0);
    check("rst_wdata",    mem_wdata, 32'd0);
    check("rst_rdata",    rdata, 32'd0);
    check("rst_rv_err",   {30'd0, rdata_valid, bus_err}, 32'd0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    // Load word, ack on first ISSUE cycle
    run_op(0, 2'b00, 3'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
    check("lw_byteen", 32'(r_be), 32'hF);
    check("lw_addr", r_addr, 32'h10);
    check("lw_stall_cycles", 32'(r_stall), 32'd2);
    check("lw_latency", 32'(r_done), 32'd2);
    check("lw_rdata", r_rdata, 32'hDEADBEEF);
    check("lw_rv", 32'(r_rv), 32'd1);

    run_op(0, 2'b10, 3'd2, 32'h13, 32'h0, 32'h80FF0000, 1);
    check("lb_s_byteen", 32'(r_be), 32'h8);
    check("lb_s_rdata", r_rdata, 32'hFFFFFF80);
    run_op(0, 2'b10, 3'd1, 32'h13, 32'h0, 32'h80FF0000, 1);
    check("lb_u_rdata", r_rdata, 32'h00000080);
    run_op(0, 2'b01, 3'd4, 32'h22, 32'h0, 32'h80011234, 2);
    check("lh_s_rdata", r_rdata, 32'hFFFF8001);
    check("lh_s_latency", 32'(r_done), 32'd3);
    run_op(0, 2'b01, 3'd3, 32'h20, 32'h0, 32'h8001F234, 1);
    check("lh_u_rdata", r_rdata, 32'h0000F234);
    run_op(0, 2'b10, 3'd7, 32'h11, 32'h0, 32'hA5A5C3C3, 1);
    check("ext7_as_none", r_rdata, 32'hA5A5C3C3);

    // Stores
    run_op(1, 2'b01, 3'd0, 32'h22, 32'h00001234, 32'h55555555, 1);
    check("sh_addr", r_addr, 32'h20);
    check("sh_byteen", 32'(r_be), 32'hC);
    check("sh_wdata", r_wdata, 32'h12341234);
    check("sh_we", 32'(r_we), 32'd1);
    check("sh_no_rv", 32'(r_rv), 32'd0);
    run_op(1, 2'b10, 3'd0, 32'h01, 32'hFFFFFFAB, 32'h0, 1);
    check("sb_byteen", 32'(r_be), 32'h2);
    check("sb_wdata", r_wdata, 32'hABABABAB);
    run_op(1, 2'b00, 3'd0, 32'h40, 32'hCAFEF00D, 32'h0, 3);
    check("sw_byteen", 32'(r_be), 32'hF);
    check("sw_wdata", r_wdata, 32'hCAFEF00D);
    check("sw_latency", 32'(r_done), 32'd4);

    // Misaligned accesses
    req_valid = 1; req_we = 0; req_size = 2'b00; req_ext = 0; req_addr = 32'h21;
    any_req = 0;
    @(negedge clk);
    check("adel", {30'd0, exc_adel, exc_ades}, 32'h2);
    check("adel_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_req) any_req = 1;
    end
    check("adel_no_req", 32'(any_req), 32'd0);
    @(posedge clk); #1;
    req_we = 1; req_size = 2'b01; req_addr = 32'h23;
    @(negedge clk);
    check("ades", {30'd0, exc_adel, exc_ades}, 32'h1);
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;

    // Timeout, then ack on the last ISSUE cycle
    run_op(0, 2'b00, 3'd0, 32'h50, 32'h0, 32'h11111111, 0);
    check("to_req_cycles", 32'(r_req), 32'd4);
    check("to_latency", 32'(r_done), 32'd5);
    check("to_bus_err", 32'(r_err), 32'd1);
    check("to_rdata", r_rdata, 32'd0);
    check("to_no_rv", 32'(r_rv), 32'd0);
    run_op(0, 2'b00, 3'd0, 32'h54, 32'h0, 32'h22223333, 4);
    check("late_ack_no_err", 32'(r_err), 32'd0);
    check("late_ack_rdata", r_rdata, 32'h22223333);
    check("late_ack_latency", 32'(r_done), 32'd5);

    // Reset during second ISSUE cycle
    req_valid = 1; req_we = 0; req_size = 2'b00; req_ext = 0; req_addr = 32'h30;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; req_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_idle", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    check("stray_ack_ignored", {29'd0, rdata_valid, bus_err, mem_req}, 32'd0);
    @(posedge clk); #1;
    run_op(0, 2'b00, 3'd0, 32'h34, 32'h0, 32'h0BADF00D, 1);
    check("post_rst_rdata", r_rdata, 32'h0BADF00D);
    check("post_rst_rv", 32'(r_rv), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
